// File: rtl/rs_station.sv
// Reservation station: holds dispatched instructions until both operands are
// resolved (directly, by dispatch-time bypass, or by CDB wake-up), then moves
// the lowest-index ready entry into a single-entry issue register that feeds
// the execution unit over a valid/ready handshake.
module rs_station #(
  parameter int RS_DEPTH_LOG = 4,
  parameter int TAG_WIDTH    = 4,
  parameter int OP_WIDTH     = 6,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [OP_WIDTH-1:0]     disp_op,
  input  logic [TAG_WIDTH-1:0]    disp_q1,
  input  logic [TAG_WIDTH-1:0]    disp_q2,
  input  logic [DATA_WIDTH-1:0]   disp_v1,
  input  logic [DATA_WIDTH-1:0]   disp_v2,
  input  logic [TAG_WIDTH-1:0]    disp_dest,
  input  logic                    cdb_valid,
  input  logic [TAG_WIDTH-1:0]    cdb_tag,
  input  logic [DATA_WIDTH-1:0]   cdb_value,
  input  logic                    flush,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [OP_WIDTH-1:0]     iss_op,
  output logic [TAG_WIDTH-1:0]    iss_dest,
  output logic [DATA_WIDTH-1:0]   iss_v1,
  output logic [DATA_WIDTH-1:0]   iss_v2,
  output logic                    full,
  output logic [RS_DEPTH_LOG:0]   count
);

  localparam int DEPTH = 2 ** RS_DEPTH_LOG;
  localparam logic [RS_DEPTH_LOG:0] FULL_CNT = (RS_DEPTH_LOG + 1)'(DEPTH);
  localparam logic [RS_DEPTH_LOG:0] CNT_ONE  = (RS_DEPTH_LOG + 1)'(1);

  // Entry storage (stage p0); only busy is a control bit, the rest is payload.
  logic                  ent_busy_p0 [DEPTH];
  logic [OP_WIDTH-1:0]   ent_op_p0   [DEPTH];
  logic [TAG_WIDTH-1:0]  ent_q1_p0   [DEPTH];
  logic [TAG_WIDTH-1:0]  ent_q2_p0   [DEPTH];
  logic [DATA_WIDTH-1:0] ent_v1_p0   [DEPTH];
  logic [DATA_WIDTH-1:0] ent_v2_p0   [DEPTH];
  logic [TAG_WIDTH-1:0]  ent_dest_p0 [DEPTH];
  logic [RS_DEPTH_LOG:0] cnt_p0;

  // Issue register (stage p1).
  logic                  vld_p1;
  logic [OP_WIDTH-1:0]   iss_op_p1;
  logic [TAG_WIDTH-1:0]  iss_dest_p1;
  logic [DATA_WIDTH-1:0] iss_v1_p1;
  logic [DATA_WIDTH-1:0] iss_v2_p1;

  logic                    sel_found;
  logic [RS_DEPTH_LOG-1:0] sel_idx;
  logic                    free_found;
  logic [RS_DEPTH_LOG-1:0] free_idx;
  logic                    cdb_hit;
  logic                    disp_acc;
  logic                    iss_load;
  logic                    iss_take;

  assign full       = (cnt_p0 == FULL_CNT);
  assign disp_ready = !full;
  assign count      = cnt_p0;
  assign iss_valid  = vld_p1;
  assign iss_op     = iss_op_p1;
  assign iss_dest   = iss_dest_p1;
  assign iss_v1     = iss_v1_p1;
  assign iss_v2     = iss_v2_p1;

  assign cdb_hit  = cdb_valid && (cdb_tag != '0);
  assign disp_acc = disp_valid && disp_ready && free_found;
  assign iss_load = !vld_p1 || iss_ready;
  assign iss_take = iss_load && sel_found;

  // Lowest-index executable entry and lowest-index free entry, from registered state.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_busy_p0[i] && (ent_q1_p0[i] == '0) && (ent_q2_p0[i] == '0)) begin
        sel_found = 1'b1;
        sel_idx   = RS_DEPTH_LOG'(i);
      end
      if (!ent_busy_p0[i]) begin
        free_found = 1'b1;
        free_idx   = RS_DEPTH_LOG'(i);
      end
    end
  end

  // Entry update: wake-up, dispatch with bypass, issue select, occupancy count.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent_busy_p0[i] <= 1'b0;
      cnt_p0 <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent_busy_p0[i] <= 1'b0;
        cnt_p0 <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_busy_p0[i] && cdb_hit) begin
            if (ent_q1_p0[i] == cdb_tag) begin
              ent_q1_p0[i] <= '0;
              ent_v1_p0[i] <= cdb_value;
            end
            if (ent_q2_p0[i] == cdb_tag) begin
              ent_q2_p0[i] <= '0;
              ent_v2_p0[i] <= cdb_value;
            end
          end
        end
        if (iss_take) ent_busy_p0[sel_idx] <= 1'b0;
        if (disp_acc) begin
          ent_busy_p0[free_idx] <= 1'b1;
          ent_op_p0[free_idx]   <= disp_op;
          ent_dest_p0[free_idx] <= disp_dest;
          if (cdb_hit && (disp_q1 == cdb_tag)) begin
            ent_q1_p0[free_idx] <= '0;
            ent_v1_p0[free_idx] <= cdb_value;
          end else begin
            ent_q1_p0[free_idx] <= disp_q1;
            ent_v1_p0[free_idx] <= disp_v1;
          end
          if (cdb_hit && (disp_q2 == cdb_tag)) begin
            ent_q2_p0[free_idx] <= '0;
            ent_v2_p0[free_idx] <= cdb_value;
          end else begin
            ent_q2_p0[free_idx] <= disp_q2;
            ent_v2_p0[free_idx] <= disp_v2;
          end
        end
        case ({disp_acc, iss_take})
          2'b10:   cnt_p0 <= cnt_p0 + CNT_ONE;
          2'b01:   cnt_p0 <= cnt_p0 - CNT_ONE;
          default: cnt_p0 <= cnt_p0;
        endcase
      end
    end
  end

  // ---- stage boundary p0 -> p1: issue register ----
  // Loads the selected entry when empty or being consumed; holds otherwise.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p1      <= 1'b0;
      iss_op_p1   <= '0;
      iss_dest_p1 <= '0;
      iss_v1_p1   <= '0;
      iss_v2_p1   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (iss_load) begin
        vld_p1 <= sel_found;
        if (sel_found) begin
          iss_op_p1   <= ent_op_p0[sel_idx];
          iss_dest_p1 <= ent_dest_p0[sel_idx];
          iss_v1_p1   <= ent_v1_p0[sel_idx];
          iss_v2_p1   <= ent_v2_p0[sel_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: scoreboard of expected issued instructions plus
// direct checks of count/full/handshake behaviour.
module tb_rs_station;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        disp_valid, disp_ready;
  logic [5:0]  disp_op;
  logic [3:0]  disp_q1, disp_q2, disp_dest;
  logic [31:0] disp_v1, disp_v2;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        flush;
  logic        iss_valid, iss_ready;
  logic [5:0]  iss_op;
  logic [3:0]  iss_dest;
  logic [31:0] iss_v1, iss_v2;
  logic        full;
  logic [4:0]  count;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  rs_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_dest(disp_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .flush(flush), .iss_valid(iss_valid),
    .iss_ready(iss_ready), .iss_op(iss_op), .iss_dest(iss_dest),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .full(full), .count(count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_disp(input logic [5:0] op, input logic [3:0] q1, input logic [3:0] q2,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] dest);
    disp_valid = 1'b1;
    disp_op    = op;
    disp_q1    = q1;
    disp_q2    = q2;
    disp_v1    = v1;
    disp_v2    = v2;
    disp_dest  = dest;
  endtask

  // Scoreboard: an instruction is consumed on the next edge when valid && ready.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && !flush && iss_valid && iss_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(iss_op), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_op",   64'(iss_op),   64'(e.op));
        check("sb_v1",   64'(iss_v1),   64'(e.v1));
        check("sb_v2",   64'(iss_v2),   64'(e.v2));
        check("sb_dest", 64'(iss_dest), 64'(e.dest));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    disp_valid = 1'b0; disp_op = '0; disp_q1 = '0; disp_q2 = '0;
    disp_v1 = '0; disp_v2 = '0; disp_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; iss_ready = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
    check("rst_iss_valid", 64'(iss_valid), 0);
    check("rst_iss_op",    64'(iss_op), 0);
    check("rst_iss_v1",    64'(iss_v1), 0);
    check("rst_iss_v2",    64'(iss_v2), 0);
    check("rst_iss_dest",  64'(iss_dest), 0);
    check("rst_count",     64'(count), 0);
    check("rst_full",      64'(full), 0);
    check("rst_disp_rdy",  64'(disp_ready), 1);

    // Minimum latency, both operands present.
    set_disp(6'd3, 4'd0, 4'd0, 32'd5, 32'd7, 4'd2);
    sb.push_back('{op: 6'd3, v1: 32'd5, v2: 32'd7, dest: 4'd2});
    tick();
    disp_valid = 1'b0;
    check("lat_count1", 64'(count), 1);
    check("lat_vld_E",  64'(iss_valid), 0);
    tick();
    check("lat_vld_E1", 64'(iss_valid), 1);
    check("lat_v1",     64'(iss_v1), 5);
    check("lat_v2",     64'(iss_v2), 7);
    check("lat_dest",   64'(iss_dest), 2);
    check("lat_count0", 64'(count), 0);
    iss_ready = 1'b1;
    tick();
    check("lat_drain", 64'(iss_valid), 0);

    // CDB wake-up one cycle after dispatch.
    set_disp(6'd4, 4'd4, 4'd0, 32'd0, 32'h11, 4'd3);
    sb.push_back('{op: 6'd4, v1: 32'hAA, v2: 32'h11, dest: 4'd3});
    tick();
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_value = 32'hAA;
    tick();
    cdb_valid = 1'b0;
    check("wake_not_yet", 64'(iss_valid), 0);
    check("wake_count",   64'(count), 1);
    tick();
    check("wake_vld", 64'(iss_valid), 1);
    check("wake_v1",  64'(iss_v1), 32'hAA);
    tick();

    // Dispatch-time bypass.
    set_disp(6'd5, 4'd6, 4'd0, 32'd0, 32'h22, 4'd4);
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'hAA;
    sb.push_back('{op: 6'd5, v1: 32'hAA, v2: 32'h22, dest: 4'd4});
    tick();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    check("byp_vld", 64'(iss_valid), 1);
    check("byp_v1",  64'(iss_v1), 32'hAA);
    tick();

    // Fill all entries waiting on tag 9, then broadcast.
    iss_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      set_disp(6'(k), 4'd9, 4'd0, 32'd0, 32'(k + 100), 4'(k));
      sb.push_back('{op: 6'(k), v1: 32'h99, v2: 32'(k + 100), dest: 4'(k)});
      tick();
    end
    check("fill_count", 64'(count), 16);
    check("fill_full",  64'(full), 1);
    check("fill_drdy",  64'(disp_ready), 0);
    set_disp(6'd63, 4'd0, 4'd0, 32'd1, 32'd1, 4'd15);
    tick();
    disp_valid = 1'b0;
    check("fill_17th_count", 64'(count), 16);
    check("fill_17th_vld",   64'(iss_valid), 0);
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'h99; iss_ready = 1'b1;
    tick();
    cdb_valid = 1'b0;
    check("fill_wake_vld", 64'(iss_valid), 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("b2b_vld",   64'(iss_valid), 1);
      check("b2b_order", 64'(iss_op), 64'(k));
      check("b2b_count", 64'(count), 64'(15 - k));
    end
    tick();
    check("b2b_drain", 64'(iss_valid), 0);

    // Back-pressure hold.
    iss_ready = 1'b0;
    set_disp(6'd7, 4'd0, 4'd0, 32'd1, 32'd2, 4'd5);
    sb.push_back('{op: 6'd7, v1: 32'd1, v2: 32'd2, dest: 4'd5});
    tick();
    set_disp(6'd8, 4'd0, 4'd0, 32'd3, 32'd4, 4'd6);
    sb.push_back('{op: 6'd8, v1: 32'd3, v2: 32'd4, dest: 4'd6});
    tick();
    disp_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_vld",   64'(iss_valid), 1);
      check("hold_op",    64'(iss_op), 7);
      check("hold_v1",    64'(iss_v1), 1);
      check("hold_dest",  64'(iss_dest), 5);
      check("hold_count", 64'(count), 1);
    end
    iss_ready = 1'b1;
    tick();
    check("rel_op",    64'(iss_op), 8);
    check("rel_count", 64'(count), 0);
    tick();
    check("rel_drain", 64'(iss_valid), 0);

    // Flush with three busy entries and a loaded issue register.
    iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_disp(6'(20 + k), 4'd0, 4'd0, 32'd0, 32'd0, 4'd1);
      tick();
    end
    check("pre_flush_count", 64'(count), 3);
    check("pre_flush_vld",   64'(iss_valid), 1);
    set_disp(6'd30, 4'd0, 4'd0, 32'd0, 32'd0, 4'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; disp_valid = 1'b0;
    check("flush_count", 64'(count), 0);
    check("flush_vld",   64'(iss_valid), 0);
    tick();
    check("flush_no_new_cnt", 64'(count), 0);
    check("flush_no_new_vld", 64'(iss_valid), 0);

    // rdy_in low freezes everything.
    set_disp(6'd10, 4'd0, 4'd0, 32'h10, 32'h20, 4'd7);
    sb.push_back('{op: 6'd10, v1: 32'h10, v2: 32'h20, dest: 4'd7});
    tick();
    set_disp(6'd11, 4'd12, 4'd0, 32'd0, 32'h30, 4'd8);
    sb.push_back('{op: 6'd11, v1: 32'h55, v2: 32'h30, dest: 4'd8});
    tick();
    rdy_in = 1'b0;
    set_disp(6'd15, 4'd0, 4'd0, 32'd9, 32'd9, 4'd9);
    cdb_valid = 1'b1; cdb_tag = 4'd12; cdb_value = 32'h77; iss_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("frz_count", 64'(count), 1);
      check("frz_vld",   64'(iss_valid), 1);
      check("frz_op",    64'(iss_op), 10);
      check("frz_v1",    64'(iss_v1), 32'h10);
    end
    rdy_in = 1'b1; disp_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    check("resume_vld",   64'(iss_valid), 0);
    check("resume_count", 64'(count), 1);
    cdb_valid = 1'b1; cdb_tag = 4'd12; cdb_value = 32'h55;
    tick();
    cdb_valid = 1'b0;
    tick();
    check("resume_op", 64'(iss_op), 11);
    check("resume_v1", 64'(iss_v1), 32'h55);
    tick();
    check("end_vld",  64'(iss_valid), 0);
    check("sb_empty", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_station.md
# rs_station

Parametrised reservation station for the Tomasulo out-of-order RISC-V core. It sits between the issue/decode stage and one execution unit. It holds dispatched instructions with their operand tags and values, and captures results broadcast on the common data bus (CDB). It hands ready instructions to the execution unit through a valid/ready handshake, and it clears all contents on a pipeline flush.

## Interface
Parameters:
- RS_DEPTH_LOG, 4, log2 of entry count; DEPTH = 2**RS_DEPTH_LOG.
- TAG_WIDTH, 4, ROB tag width; tag 0 means "operand value present, no dependency".
- OP_WIDTH, 6, width of the decoded opcode field carried to the execution unit.
- DATA_WIDTH, 32, operand/result width.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  = !full; a dispatch is accepted on an edge where disp_valid && disp_ready && rdy_in.
- disp_op  in  OP_WIDTH  opcode.
- disp_q1, disp_q2  in  TAG_WIDTH  producing ROB tag per operand, 0 if value valid.
- disp_v1, disp_v2  in  DATA_WIDTH  operand value (meaningful when the matching q is 0).
- disp_dest  in  TAG_WIDTH  ROB tag of this instruction's result.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_WIDTH  producing ROB tag.
- cdb_value  in  DATA_WIDTH  result value.
- flush  in  1  misprediction flush.
- iss_valid  out  1  issue register holds an instruction.
- iss_ready  in  1  execution unit accepts it this cycle.
- iss_op, iss_dest  out  OP_WIDTH / TAG_WIDTH  opcode and destination tag of the issued instruction.
- iss_v1, iss_v2  out  DATA_WIDTH  resolved operands.
- full  out  1  count == DEPTH.
- count  out  RS_DEPTH_LOG+1  number of busy entries; the issue register is not counted.

## Operation
- Each entry holds busy, op, q1, q2, v1, v2 and dest. An entry is executable when busy && q1==0 && q2==0, evaluated on registered entry state.
- Dispatch writes the lowest-index non-busy entry.
- Dispatch bypass: if cdb_valid and cdb_tag!=0 and disp_qN==cdb_tag on the same edge, the entry stores qN=0 and vN=cdb_value.
- Wake-up: on cdb_valid with cdb_tag!=0, every busy entry with qN==cdb_tag sets qN=0 and vN=cdb_value. Both operands may match in the same cycle. cdb_tag==0 is ignored.
- Issue register loads when it is empty or being consumed (!iss_valid || iss_ready):
  - It takes the lowest-index executable entry. That entry's busy clears on the same edge. iss_valid is set.
  - If no entry is executable, iss_valid clears when consumed.
- While iss_valid && !iss_ready, the issue register holds and its outputs stay stable.
- count updates each edge by +1 for an accepted dispatch and -1 for an entry moved to the issue register. Both may happen on one edge, giving a net change of 0.
- flush (when rdy_in): all busy clear, iss_valid clears and count goes to 0. A simultaneous dispatch and CDB update are dropped.
- rdy_in low: no state changes. All inputs are ignored and outputs hold.
- Priority: rst_in > !rdy_in > flush > normal operation.

## Timing
- Reset values:
  - iss_valid=0; iss_op, iss_v1, iss_v2, iss_dest = 0.
  - All busy=0; count=0, full=0, disp_ready=1.
- disp_ready and full derive from registered count only. When full, no dispatch is accepted, even on an edge where an entry moves to the issue register.
- Minimum latency, dispatch with both tags 0:
  - Accepted on edge E.
  - Moved to the issue register on edge E+1.
  - iss_valid high after E+1.
- An entry woken by the CDB on edge E is eligible for selection in the cycle after E and reaches the issue register at edge E+1. The same applies to a bypassed dispatch.
- Back-to-back issue: with iss_ready held high and executable entries present, one instruction issues per cycle.
- CDB values are not forwarded into the issue register; operands are final once loaded.

## Test plan
- Reset, then dispatch op=3, q1=q2=0, v1=5, v2=7, dest=2. Required: iss_valid=1 two edges later with iss_v1=5, iss_v2=7, iss_dest=2; count 1 then 0.
- Dispatch with q1=4. On the next cycle drive cdb_valid, tag 4, value 0xAA. Required: entry issues one edge later with iss_v1=0xAA. Repeat with the CDB on the dispatch edge: the bypass captures 0xAA.
- Fill 16 entries, all with q1=9, holding iss_ready=0. Required: full=1, disp_ready=0, and a 17th dispatch is ignored. Then broadcast tag 9 with iss_ready=1. Required: entries issue in index order 0..15, one per cycle.
- Hold iss_ready=0 with iss_valid=1. Required: iss_* stable for 5 cycles and count unchanged. Releasing iss_ready must issue the next entry on the following edge.
- With 3 busy entries and iss_valid=1, assert flush together with disp_valid. Required: next cycle count=0, iss_valid=0, and no new entry present.
- Drop rdy_in for 3 cycles while driving dispatch and CDB. Required: no change in count, iss_* or entry state; operation resumes exactly when rdy_in returns high.
